// File: rtl/ebi_tx_ch_arb_if.sv
// ebi_tx_ch_arb_if
//   Signal bundle of the m1->m2 EBI transmit channel scheduler: per-channel
//   message requests, the beat stream towards the bus serializer, and the
//   credit return / credit status path.
//   master : the scheduler (ebi_tx_ch_arb)
//   slave  : the surrounding holding registers, serializer and credit source
interface ebi_tx_ch_arb_if #(
   parameter int NUM_CH   = 5,
   parameter int LEN_W    = 4,
   parameter int CREDIT_W = 4
);
   localparam int CH_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0]          req_valid_i;
   logic [NUM_CH*LEN_W-1:0]    req_len_i;
   logic [NUM_CH-1:0]          req_ready_o;
   logic                       ser_valid_o;
   logic                       ser_ready_i;
   logic [CH_W-1:0]            ser_ch_o;
   logic [LEN_W-1:0]           ser_beat_o;
   logic                       ser_sof_o;
   logic                       ser_eof_o;
   logic [NUM_CH-1:0]          credit_ret_i;
   logic [NUM_CH*CREDIT_W-1:0] credit_cnt_o;
   logic                       credit_err_o;
   logic                       busy_o;

   modport master (
      input  req_valid_i, req_len_i, ser_ready_i, credit_ret_i,
      output req_ready_o, ser_valid_o, ser_ch_o, ser_beat_o, ser_sof_o,
             ser_eof_o, credit_cnt_o, credit_err_o, busy_o
   );

   modport slave (
      output req_valid_i, req_len_i, ser_ready_i, credit_ret_i,
      input  req_ready_o, ser_valid_o, ser_ch_o, ser_beat_o, ser_sof_o,
             ser_eof_o, credit_cnt_o, credit_err_o, busy_o
   );
endinterface

// File: rtl/ebi_tx_ch_arb.sv
// ebi_tx_ch_arb
//   Credit-aware channel scheduler of the m1->m2 EBI transmit path (m1_clk
//   domain). Picks one AR/AW/W/CR/CD message at a time, streams it beat by
//   beat to the serializer and keeps one credit counter per channel that is
//   spent at grant and refilled by credit returns from m2.
//   Optional feature macro: EBI_ARB_HI_PRIO_EN -- when defined, eligible
//   channels in HI_PRIO_MASK (snoop responses) win over all others so that
//   CR/CD never queue behind request traffic. Default build: plain
//   round-robin over all channels.
//   Requires NUM_CH >= 2.
module ebi_tx_ch_arb #(
   parameter int                NUM_CH       = 5,
   parameter int                LEN_W        = 4,
   parameter int                MAX_CREDIT   = 8,
   parameter int                CREDIT_W     = 4,
   parameter logic [NUM_CH-1:0] HI_PRIO_MASK = 5'b11000
) (
   input  logic            m1_clk,
   input  logic            rst,
   ebi_tx_ch_arb_if.master bus
);
   localparam int                  CH_W     = $clog2(NUM_CH);
   localparam int                  PW       = CH_W + 1;
   localparam logic [CH_W-1:0]     LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(MAX_CREDIT);

   // Priority class mask; an all-zero mask collapses the two-level pick
   // into a single round-robin over every channel.
`ifdef EBI_ARB_HI_PRIO_EN
   localparam logic [NUM_CH-1:0] HI_MASK_EFF = HI_PRIO_MASK;
`else
   localparam logic [NUM_CH-1:0] HI_MASK_EFF = HI_PRIO_MASK & {NUM_CH{1'b0}};
`endif

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [CH_W-1:0]     ch_r;
   logic [LEN_W-1:0]    len_r;
   logic [LEN_W-1:0]    beat_r;
   logic                sof_r;
   logic                eof_r;
   logic [CH_W-1:0]     rr_ptr_r;
   logic [CREDIT_W-1:0] cred_r [NUM_CH];
   logic                err_r;

   logic                in_send_s;
   logic                accept_s;
   logic                eof_acc_s;
   logic                arb_en_s;
   logic [CH_W-1:0]     start_s;
   logic [NUM_CH-1:0]   elig_s;
   logic [NUM_CH-1:0]   hi_elig_s;
   logic [PW-1:0]       pick_s;
   logic                grant_s;
   logic [CH_W-1:0]     grant_ch_s;
   logic [NUM_CH-1:0]   grant_vec_s;
   logic [LEN_W-1:0]    len_raw_s;
   logic [LEN_W-1:0]    grant_len_s;
   logic [NUM_CH-1:0]   ovf_s;

   // Channel following ch, wrapping at NUM_CH.
   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
      return (ch == LAST_CH) ? {CH_W{1'b0}} : ch + CH_W'(1);
   endfunction

   // First set bit of elig at or after start, wrapping; MSB of result = found.
   // Scanning from the farthest offset down lets the nearest hit win.
   function automatic logic [PW-1:0] rr_pick(input logic [NUM_CH-1:0] elig,
                                             input logic [CH_W-1:0]   start);
      logic [PW-1:0] res;
      logic [PW-1:0] idx;
      res = {PW{1'b0}};
      idx = {PW{1'b0}};
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = {1'b0, start} + PW'(i);
         idx = (idx >= PW'(NUM_CH)) ? idx - PW'(NUM_CH) : idx;
         res = elig[idx[CH_W-1:0]] ? {1'b1, idx[CH_W-1:0]} : res;
      end
      return res;
   endfunction

   // Handshake decode, eligibility and grant selection for the current cycle
   always_comb begin
      in_send_s = (state_r == ST_SEND);
      accept_s  = in_send_s & bus.ser_ready_i;
      eof_acc_s = accept_s & eof_r;
      arb_en_s  = (state_r == ST_IDLE) | eof_acc_s;
      // On the closing beat the pointer is about to move past ch_r, so
      // search from there already to keep the no-bubble handover fair.
      start_s   = eof_acc_s ? next_ch(ch_r) : rr_ptr_r;
      elig_s    = {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         elig_s[c] = bus.req_valid_i[c] & (cred_r[c] != {CREDIT_W{1'b0}})
                   & ~(in_send_s & (ch_r == CH_W'(c)));
      end
      hi_elig_s = elig_s & HI_MASK_EFF;
      pick_s    = (|hi_elig_s) ? rr_pick(hi_elig_s, start_s) : rr_pick(elig_s, start_s);
      grant_s   = arb_en_s & pick_s[PW-1];
      grant_ch_s = pick_s[CH_W-1:0];
      grant_vec_s = {NUM_CH{1'b0}};
      grant_vec_s[grant_ch_s] = grant_s;
      len_raw_s   = bus.req_len_i[int'(grant_ch_s) * LEN_W +: LEN_W];
      grant_len_s = (len_raw_s == {LEN_W{1'b0}}) ? LEN_W'(1) : len_raw_s;
   end

   // Credit overflow: a return with no simultaneous consume at the ceiling
   always_comb begin
      ovf_s = {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         ovf_s[c] = bus.credit_ret_i[c] & ~grant_vec_s[c] & (cred_r[c] == CRED_MAX);
      end
   end

   // FSM state register
   always_ff @(posedge m1_clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: a grant on the closing beat keeps SEND without a bubble
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_s) state_nxt_s = ST_SEND;
            else         state_nxt_s = ST_IDLE;
         end
         ST_SEND: begin
            if (eof_acc_s & ~grant_s) state_nxt_s = ST_IDLE;
            else                      state_nxt_s = ST_SEND;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM outputs; req_ready is combinational so the holding register drops
   // its valid at the same edge that completes the message
   always_comb begin
      bus.ser_valid_o  = in_send_s;
      bus.busy_o       = in_send_s;
      bus.ser_ch_o     = ch_r;
      bus.ser_beat_o   = beat_r;
      bus.ser_sof_o    = sof_r;
      bus.ser_eof_o    = eof_r;
      bus.credit_err_o = err_r;
      bus.req_ready_o  = {NUM_CH{1'b0}};
      bus.req_ready_o[ch_r] = eof_acc_s;
      bus.credit_cnt_o = {(NUM_CH*CREDIT_W){1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         bus.credit_cnt_o[c*CREDIT_W +: CREDIT_W] = cred_r[c];
      end
   end

   // Message context: latched at grant, stepped per accepted beat, cleared when idle
   always_ff @(posedge m1_clk) begin
      if (rst) begin
         ch_r   <= {CH_W{1'b0}};
         len_r  <= {LEN_W{1'b0}};
         beat_r <= {LEN_W{1'b0}};
         sof_r  <= 1'b0;
         eof_r  <= 1'b0;
      end else if (grant_s) begin
         ch_r   <= grant_ch_s;
         len_r  <= grant_len_s;
         beat_r <= {LEN_W{1'b0}};
         sof_r  <= 1'b1;
         eof_r  <= (grant_len_s == LEN_W'(1));
      end else if (eof_acc_s) begin
         ch_r   <= {CH_W{1'b0}};
         len_r  <= {LEN_W{1'b0}};
         beat_r <= {LEN_W{1'b0}};
         sof_r  <= 1'b0;
         eof_r  <= 1'b0;
      end else if (accept_s) begin
         beat_r <= beat_r + LEN_W'(1);
         sof_r  <= 1'b0;
         eof_r  <= ((beat_r + LEN_W'(1)) == (len_r - LEN_W'(1)));
      end
   end

   // Round-robin pointer moves past the channel whose message just completed
   always_ff @(posedge m1_clk) begin
      if (rst) begin
         rr_ptr_r <= {CH_W{1'b0}};
      end else if (eof_acc_s) begin
         rr_ptr_r <= next_ch(ch_r);
      end
   end

   // Per-channel credit counters: spend at grant, refill on return, saturate at max
   always_ff @(posedge m1_clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (rst) begin
            cred_r[c] <= CRED_MAX;
         end else begin
            case ({bus.credit_ret_i[c], grant_vec_s[c]})
               2'b10: begin
                  if (cred_r[c] != CRED_MAX) cred_r[c] <= cred_r[c] + CREDIT_W'(1);
               end
               2'b01:   cred_r[c] <= cred_r[c] - CREDIT_W'(1);
               default: cred_r[c] <= cred_r[c];
            endcase
         end
      end
   end

   // Sticky credit error flag
   always_ff @(posedge m1_clk) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (|ovf_s) begin
         err_r <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ebi_tx_ch_arb.sv
// tb_ebi_tx_ch_arb
//   Directed scenarios plus randomized traffic for ebi_tx_ch_arb, checked
//   every cycle against a transaction-level reference model of the scheduler.
//   Honours EBI_ARB_HI_PRIO_EN the same way as the design.
module tb_ebi_tx_ch_arb;
   localparam int NUM_CH = 5, LEN_W = 4, MAX_CREDIT = 8, CREDIT_W = 4;
   localparam logic [NUM_CH-1:0] HI_MASK = 5'b11000;

   logic m1_clk;
   logic rst;

   initial m1_clk = 1'b0;
   always #5 m1_clk = ~m1_clk;

   ebi_tx_ch_arb_if #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .CREDIT_W(CREDIT_W)) bus ();

   ebi_tx_ch_arb #(
      .NUM_CH(NUM_CH), .LEN_W(LEN_W), .MAX_CREDIT(MAX_CREDIT),
      .CREDIT_W(CREDIT_W), .HI_PRIO_MASK(HI_MASK)
   ) dut (
      .m1_clk(m1_clk),
      .rst   (rst),
      .bus   (bus)
   );

   int num_checks = 0;
   int num_errors = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      num_checks++;
      if (obs !== exp) begin
         num_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model (message level) ----------------
   int m_ch;               // channel in flight, -1 when idle
   int m_len, m_beat, m_rr;
   int m_cred [NUM_CH];
   bit m_err;

   typedef struct {
      bit                vld;
      int                ch;
      int                beat;
      bit                sof;
      bit                eof;
      logic [NUM_CH-1:0] rdy;
   } obs_t;
   obs_t trace[$];

   task automatic model_reset();
      m_ch = -1; m_len = 1; m_beat = 0; m_rr = 0; m_err = 1'b0;
      for (int c = 0; c < NUM_CH; c++) m_cred[c] = MAX_CREDIT;
   endtask

   function automatic int rr_search(input int start, input logic [NUM_CH-1:0] allow);
      for (int k = 0; k < NUM_CH; k++) begin
         int c = (start + k) % NUM_CH;
         if (allow[c] && bus.req_valid_i[c] && m_cred[c] > 0 && c != m_ch) return c;
      end
      return -1;
   endfunction

   task automatic model_step();
      bit vld, acc, eof_acc, ret, con;
      int start, grant;
      if (rst) begin
         model_reset();
      end else begin
         vld     = (m_ch >= 0);
         acc     = vld && bus.ser_ready_i;
         eof_acc = acc && (m_beat == m_len - 1);
         grant   = -1;
         if (!vld || eof_acc) begin
            start = eof_acc ? (m_ch + 1) % NUM_CH : m_rr;
`ifdef EBI_ARB_HI_PRIO_EN
            grant = rr_search(start, HI_MASK);
`endif
            if (grant < 0) grant = rr_search(start, {NUM_CH{1'b1}});
         end
         for (int c = 0; c < NUM_CH; c++) begin
            ret = bus.credit_ret_i[c];
            con = (grant == c);
            if (ret && !con) begin
               if (m_cred[c] == MAX_CREDIT) m_err = 1'b1;
               else m_cred[c]++;
            end else if (con && !ret) begin
               m_cred[c]--;
            end
         end
         if (eof_acc) m_rr = (m_ch + 1) % NUM_CH;
         if (grant >= 0) begin
            m_ch   = grant;
            m_len  = int'(bus.req_len_i[grant*LEN_W +: LEN_W]);
            if (m_len == 0) m_len = 1;
            m_beat = 0;
         end else if (eof_acc) begin
            m_ch = -1;
         end else if (acc) begin
            m_beat++;
         end
      end
   endtask

   task automatic compare_all();
      logic [NUM_CH*CREDIT_W-1:0] ecred;
      logic [NUM_CH-1:0]          erdy;
      bit   ev, elast;
      obs_t o;
      ev    = (m_ch >= 0);
      elast = ev && (m_beat == m_len - 1);
      erdy  = '0;
      if (elast && bus.ser_ready_i) erdy[m_ch] = 1'b1;
      for (int c = 0; c < NUM_CH; c++) ecred[c*CREDIT_W +: CREDIT_W] = CREDIT_W'(m_cred[c]);
      chk_eq("ser_valid",  32'(bus.ser_valid_o),  32'(ev));
      chk_eq("busy",       32'(bus.busy_o),       32'(ev));
      chk_eq("ser_ch",     32'(bus.ser_ch_o),     ev ? m_ch : 0);
      chk_eq("ser_beat",   32'(bus.ser_beat_o),   ev ? m_beat : 0);
      chk_eq("ser_sof",    32'(bus.ser_sof_o),    32'(ev && m_beat == 0));
      chk_eq("ser_eof",    32'(bus.ser_eof_o),    32'(elast));
      chk_eq("req_ready",  32'(bus.req_ready_o),  32'(erdy));
      chk_eq("credit_cnt", 32'(bus.credit_cnt_o), 32'(ecred));
      chk_eq("credit_err", 32'(bus.credit_err_o), 32'(m_err));
      o.vld = bus.ser_valid_o; o.ch = int'(bus.ser_ch_o); o.beat = int'(bus.ser_beat_o);
      o.sof = bus.ser_sof_o;   o.eof = bus.ser_eof_o;     o.rdy = bus.req_ready_o;
      trace.push_back(o);
   endtask

   // One clock: compare on the falling edge, advance the model on the rising edge.
   task automatic tick();
      @(negedge m1_clk);
      compare_all();
      @(posedge m1_clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_valid_i = '0; bus.req_len_i = '0; bus.ser_ready_i = 1'b1; bus.credit_ret_i = '0;
   endtask

   task automatic do_reset(input int n);
      idle_inputs();
      rst = 1'b1;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   function automatic int count_ch(input int ch);
      int n = 0;
      foreach (trace[i]) if (trace[i].vld && trace[i].ch == ch) n++;
      return n;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t3_exp [6] = '{0, 1, 2, 3, 4, 0};
      int guard;
      idle_inputs();
      rst = 1'b1;
      @(posedge m1_clk);
      model_reset();
      #1;

      // T1 reset
      do_reset(3);
      tick();
      chk_eq("t1_credits",   32'(bus.credit_cnt_o), 32'({5{4'd8}}));
      chk_eq("t1_ser_valid", 32'(bus.ser_valid_o),  0);
      chk_eq("t1_req_ready", 32'(bus.req_ready_o),  0);
      chk_eq("t1_err",       32'(bus.credit_err_o), 0);

      // T2 single 3-beat message on ch0
      bus.req_valid_i = 5'b00001; bus.req_len_i[3:0] = 4'd3;
      trace.delete();
      tick();
      bus.req_valid_i = '0;
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         chk_eq("t2_valid", 32'(trace[1+i].vld), 1);
         chk_eq("t2_beat",  trace[1+i].beat, i);
         chk_eq("t2_sof",   32'(trace[1+i].sof), 32'(i == 0));
         chk_eq("t2_eof",   32'(trace[1+i].eof), 32'(i == 2));
         chk_eq("t2_rdy",   32'(trace[1+i].rdy), (i == 2) ? 1 : 0);
      end
      chk_eq("t2_credit0", 32'(bus.credit_cnt_o[3:0]), 7);

      // T3 round-robin, all channels single-beat
      do_reset(1);
      bus.req_valid_i = 5'b11111; bus.req_len_i = {5{4'd1}};
      trace.delete();
      repeat (7) tick();
      for (int i = 0; i < 6; i++) begin
         chk_eq("t3_valid", 32'(trace[1+i].vld), 1);
         chk_eq("t3_ch",    trace[1+i].ch, t3_exp[i]);
      end
      chk_eq("t3_credit0", 32'(bus.credit_cnt_o[3:0]),  6);
      chk_eq("t3_credit2", 32'(bus.credit_cnt_o[11:8]), 7);

      // T4 credit exhaustion, skip, refill, return+consume, overflow
      do_reset(1);
      bus.req_valid_i = 5'b00010; bus.req_len_i = {5{4'd1}};
      trace.delete();
      guard = 0;
      while (m_cred[1] > 0 && guard < 40) begin tick(); guard++; end
      chk_eq("t4_drain_bound", 32'(guard < 40), 1);
      repeat (2) tick();
      chk_eq("t4_ch1_msgs",    count_ch(1), 8);
      chk_eq("t4_credit1_zero", 32'(bus.credit_cnt_o[7:4]), 0);
      bus.req_valid_i = 5'b00110;
      trace.delete();
      repeat (6) tick();
      chk_eq("t4_ch1_skipped", count_ch(1), 0);
      chk_eq("t4_ch2_served",  32'(count_ch(2) > 0), 1);
      bus.credit_ret_i[1] = 1'b1;
      tick();
      bus.credit_ret_i = '0;
      trace.delete();
      repeat (3) tick();
      chk_eq("t4_ch1_regrant", 32'(count_ch(1) > 0), 1);
      bus.req_valid_i = '0;
      repeat (3) tick();
      bus.req_valid_i = 5'b00001;
      tick();
      bus.req_valid_i = '0;
      repeat (2) tick();
      bus.req_valid_i = 5'b00001; bus.credit_ret_i[0] = 1'b1;
      tick();
      bus.req_valid_i = '0; bus.credit_ret_i = '0;
      chk_eq("t4_ret_and_consume", 32'(bus.credit_cnt_o[3:0]), 7);
      repeat (2) tick();
      chk_eq("t4_err_before", 32'(bus.credit_err_o), 0);
      bus.credit_ret_i[4] = 1'b1;
      tick();
      bus.credit_ret_i = '0;
      chk_eq("t4_err_set",  32'(bus.credit_err_o), 1);
      chk_eq("t4_credit4",  32'(bus.credit_cnt_o[19:16]), 8);

      // T5 backpressure at beat 1, then reset mid-message
      do_reset(1);
      bus.req_valid_i = 5'b00001; bus.req_len_i[3:0] = 4'd4;
      tick();
      bus.req_valid_i = '0;
      tick();
      bus.ser_ready_i = 1'b0;
      trace.delete();
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         chk_eq("t5_hold_beat", trace[i].beat, 1);
         chk_eq("t5_no_ready",  32'(trace[i].rdy), 0);
      end
      bus.ser_ready_i = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_eq("t5_rst_valid",  32'(bus.ser_valid_o),  0);
      chk_eq("t5_rst_busy",   32'(bus.busy_o),       0);
      chk_eq("t5_rst_credit", 32'(bus.credit_cnt_o), 32'({5{4'd8}}));
      tick();

      // T6 priority class: ch0 and ch3 requesting from IDLE after reset
      do_reset(1);
      bus.req_valid_i = 5'b01001; bus.req_len_i = {5{4'd1}};
      trace.delete();
      repeat (2) tick();
`ifdef EBI_ARB_HI_PRIO_EN
      chk_eq("t6_first_ch", trace[1].ch, 3);
`else
      chk_eq("t6_first_ch", trace[1].ch, 0);
`endif

      // Randomized traffic against the model
      do_reset(1);
      for (int n = 0; n < 3000; n++) begin
         bus.req_valid_i = NUM_CH'($urandom);
         bus.req_len_i   = (NUM_CH*LEN_W)'($urandom);
         bus.ser_ready_i = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < NUM_CH; c++) bus.credit_ret_i[c] = ($urandom_range(0, 11) == 0);
         rst = ($urandom_range(0, 599) == 0);
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end
endmodule
